// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port (core/debug) arbiter in front of the single data memory
// Optional build macro DMEM_ARB_RR_EN: round-robin tie-break; fixed core priority otherwise.
module dmem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              core_req_valid,
    output logic              core_req_ready,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic [2:0]        core_func3,
    output logic              core_resp_valid,
    output logic [DATA_W-1:0] core_rdata,

    input  logic              dbg_req_valid,
    output logic              dbg_req_ready,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic [2:0]        dbg_func3,
    output logic              dbg_resp_valid,
    output logic [DATA_W-1:0] dbg_rdata,

    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic [2:0]        mem_func3,
    input  logic [DATA_W-1:0] mem_out_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [2:0]          func3_q, func3_d;
    logic                owner_q, owner_d;
    logic                last_grant_q, last_grant_d;
    logic                mem_we_q, mem_we_d;
    logic                mem_re_q, mem_re_d;
    logic                core_resp_q, core_resp_d;
    logic                dbg_resp_q, dbg_resp_d;

    logic                core_wins_tie;
    logic                core_grant;
    logic                dbg_grant;

`ifdef DMEM_ARB_RR_EN
    // last_grant = 1 means dbg was served last, so the core takes the tie
    assign core_wins_tie = last_grant_q;
`else
    // Fixed priority; last_grant is tracked but never decides a tie
    assign core_wins_tie = last_grant_q | 1'b1;
`endif

    assign core_grant     = core_req_valid && (!dbg_req_valid || core_wins_tie);
    assign dbg_grant      = dbg_req_valid && !core_grant;
    assign core_req_ready = (state_q == IDLE) && core_grant;
    assign dbg_req_ready  = (state_q == IDLE) && dbg_grant;

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        func3_d      = func3_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        mem_we_d     = 1'b0;
        mem_re_d     = 1'b0;
        core_resp_d  = 1'b0;
        dbg_resp_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (core_grant || dbg_grant) begin
                    we_d         = dbg_grant ? dbg_we    : core_we;
                    addr_d       = dbg_grant ? dbg_addr  : core_addr;
                    wdata_d      = dbg_grant ? dbg_wdata : core_wdata;
                    func3_d      = dbg_grant ? dbg_func3 : core_func3;
                    owner_d      = dbg_grant;
                    last_grant_d = dbg_grant;
                    // Strobes are registered so they are high exactly in ACCESS
                    mem_we_d     = dbg_grant ? dbg_we : core_we;
                    mem_re_d     = dbg_grant ? !dbg_we : !core_we;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                core_resp_d = !owner_q;
                dbg_resp_d  = owner_q;
                state_d     = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            func3_q      <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            core_resp_q  <= 1'b0;
            dbg_resp_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            func3_q      <= func3_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
            core_resp_q  <= core_resp_d;
            dbg_resp_q   <= dbg_resp_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign mem_addr  = addr_q;
    assign mem_data  = wdata_q;
    assign mem_func3 = func3_q;

    // Memory read data only becomes valid in RESP, so it is steered, not captured
    assign core_resp_valid = core_resp_q;
    assign dbg_resp_valid  = dbg_resp_q;
    assign core_rdata      = (core_resp_q && !we_q) ? mem_out_data : '0;
    assign dbg_rdata       = (dbg_resp_q && !we_q) ? mem_out_data : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req_valid, core_req_ready, core_we, core_resp_valid;
    logic [63:0] core_addr, core_wdata, core_rdata;
    logic [2:0]  core_func3;
    logic        dbg_req_valid, dbg_req_ready, dbg_we, dbg_resp_valid;
    logic [63:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic [2:0]  dbg_func3;
    logic        mem_we, mem_re;
    logic [63:0] mem_addr, mem_data, mem_out_data;
    logic [2:0]  mem_func3;

    dmem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .reset(reset),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_func3(core_func3), .core_resp_valid(core_resp_valid), .core_rdata(core_rdata),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
        .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_func3(dbg_func3), .dbg_resp_valid(dbg_resp_valid), .dbg_rdata(dbg_rdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_func3(mem_func3), .mem_out_data(mem_out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] data;
        logic [2:0]  f3;
        int          cyc;
    } strobe_t;

    typedef struct {
        logic        owner;
        logic [63:0] rdata;
        int          cyc;
    } resp_t;

    strobe_t sq[$];
    resp_t   rq[$];
    int      g_port[$];
    int      g_cyc[$];
    strobe_t s_e;
    resp_t   r_e;
    int      cyc = 0;
    int      n_cmp = 0;
    int      n_bad = 0;
    int      resp_seen = 0;

    function automatic logic [63:0] mem_fn(input logic [63:0] a);
        return (a == 64'h10) ? 64'hDEADBEEF_CAFEF00D : (a ^ 64'h5A5A_0000_1234_0000);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data appears the cycle after mem_re, garbage otherwise
    always @(posedge clk) begin
        mem_out_data = mem_re ? mem_fn(mem_addr) : 64'hBADBADBADBADBAD0;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (core_req_valid && dbg_req_valid)
                chk("both_ready", 64'(core_req_ready & dbg_req_ready), 64'd0);
            if (core_req_ready || dbg_req_ready) begin
                s_e.we   = dbg_req_ready ? dbg_we    : core_we;
                s_e.addr = dbg_req_ready ? dbg_addr  : core_addr;
                s_e.data = dbg_req_ready ? dbg_wdata : core_wdata;
                s_e.f3   = dbg_req_ready ? dbg_func3 : core_func3;
                s_e.cyc  = cyc + 1;
                sq.push_back(s_e);
                r_e.owner = dbg_req_ready;
                r_e.rdata = s_e.we ? 64'd0 : mem_fn(s_e.addr);
                r_e.cyc   = cyc + 2;
                rq.push_back(r_e);
                g_port.push_back(dbg_req_ready ? 1 : 0);
                g_cyc.push_back(cyc);
            end
            if (mem_we || mem_re) begin
                chk("ready_in_access", 64'(core_req_ready | dbg_req_ready), 64'd0);
                if (sq.size() == 0) begin
                    chk("unexpected_strobe", 64'd1, 64'd0);
                end else begin
                    s_e = sq.pop_front();
                    chk("mem_we", 64'(mem_we), 64'(s_e.we));
                    chk("mem_re", 64'(mem_re), 64'(!s_e.we));
                    chk("mem_addr", mem_addr, s_e.addr);
                    chk("mem_data", mem_data, s_e.data);
                    chk("mem_func3", 64'(mem_func3), 64'(s_e.f3));
                    chk("strobe_cycle", 64'(cyc), 64'(s_e.cyc));
                end
            end
            if (core_resp_valid || dbg_resp_valid) begin
                resp_seen++;
                chk("ready_in_resp", 64'(core_req_ready | dbg_req_ready), 64'd0);
                chk("resp_onehot", 64'(core_resp_valid & dbg_resp_valid), 64'd0);
                if (rq.size() == 0) begin
                    chk("unexpected_resp", 64'd1, 64'd0);
                end else begin
                    r_e = rq.pop_front();
                    chk("resp_owner", 64'(dbg_resp_valid), 64'(r_e.owner));
                    chk("resp_rdata", dbg_resp_valid ? dbg_rdata : core_rdata, r_e.rdata);
                    chk("idle_port_rdata", dbg_resp_valid ? core_rdata : dbg_rdata, 64'd0);
                    chk("resp_cycle", 64'(cyc), 64'(r_e.cyc));
                end
            end
        end
    end

    task automatic req(input bit port, input logic we, input logic [63:0] a,
                       input logic [63:0] d, input logic [2:0] f3);
        int n;
        bit done;
        n = g_port.size();
        done = 1'b0;
        @(posedge clk); #1;
        if (port) begin
            dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_func3 = f3; dbg_req_valid = 1'b1;
        end else begin
            core_we = we; core_addr = a; core_wdata = d; core_func3 = f3; core_req_valid = 1'b1;
        end
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk); #1;
            if (g_port.size() > n) done = 1'b1;
        end
        core_req_valid = 1'b0;
        dbg_req_valid  = 1'b0;
        if (!done) chk("handshake_timeout", 64'd1, 64'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (rq.size() != 0 || sq.size() != 0); i++) @(posedge clk);
        #1;
        chk("drain_resp_q", 64'(rq.size()), 64'd0);
        chk("drain_strobe_q", 64'(sq.size()), 64'd0);
    endtask

    task automatic wait_grants(input int target);
        for (int i = 0; i < 40 && g_port.size() < target; i++) begin
            @(posedge clk); #1;
        end
        core_req_valid = 1'b0;
        dbg_req_valid  = 1'b0;
        chk("grant_count", 64'(g_port.size()), 64'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int exp_order [4];
        int cnt;
        reset = 1'b1;
        core_req_valid = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0; core_func3 = '0;
        dbg_req_valid  = 1'b0; dbg_we  = 1'b0; dbg_addr  = '0; dbg_wdata  = '0; dbg_func3  = '0;
        #2;
        chk("rst_ready", 64'({core_req_ready, dbg_req_ready}), 64'd0);
        chk("rst_resp_valid", 64'({core_resp_valid, dbg_resp_valid}), 64'd0);
        chk("rst_mem_strobe", 64'({mem_we, mem_re}), 64'd0);
        chk("rst_rdata", core_rdata | dbg_rdata, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_data", mem_data, 64'd0);
        chk("rst_mem_func3", 64'(mem_func3), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Core load and debug store
        req(1'b0, 1'b0, 64'h10, 64'h0, 3'd3);
        drain();
        req(1'b1, 1'b1, 64'h20, 64'h55, 3'd2);
        drain();

        // Both ports valid for four grants
        n0 = g_port.size();
        @(posedge clk); #1;
        core_we = 1'b0; core_addr = 64'h100; core_wdata = 64'h0;    core_func3 = 3'd3;
        dbg_we  = 1'b1; dbg_addr  = 64'h200; dbg_wdata  = 64'hABCD; dbg_func3  = 3'd1;
        core_req_valid = 1'b1;
        dbg_req_valid  = 1'b1;
        wait_grants(n0 + 4);
`ifdef DMEM_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < 4; i++) begin
            if (g_port.size() > n0 + i) begin
                chk("tie_grant_port", 64'(g_port[n0 + i]), 64'(exp_order[i]));
                if (i > 0) chk("tie_grant_gap", 64'(g_cyc[n0 + i] - g_cyc[n0 + i - 1]), 64'd3);
            end
        end
        drain();

        // Core held valid: handshakes every third cycle
        n0 = g_port.size();
        @(posedge clk); #1;
        core_we = 1'b0; core_addr = 64'h30; core_func3 = 3'd0;
        core_req_valid = 1'b1;
        wait_grants(n0 + 3);
        for (int i = 1; i < 3; i++) begin
            if (g_port.size() > n0 + i)
                chk("b2b_gap", 64'(g_cyc[n0 + i] - g_cyc[n0 + i - 1]), 64'd3);
        end
        drain();

        // Reset lands in the ACCESS cycle of a store
        n0 = g_port.size();
        @(posedge clk); #1;
        core_we = 1'b1; core_addr = 64'h40; core_wdata = 64'h77; core_func3 = 3'd3;
        core_req_valid = 1'b1;
        wait_grants(n0 + 1);
        @(negedge clk); #1;
        chk("store_strobe_before_reset", 64'(mem_we), 64'd1);
        reset = 1'b1;
        rq.delete();
        #1;
        chk("async_mem_we_drop", 64'(mem_we), 64'd0);
        cnt = resp_seen;
        @(negedge clk); #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("no_resp_after_reset", 64'(resp_seen), 64'(cnt));
        req(1'b0, 1'b0, 64'h10, 64'h0, 3'd3);
        drain();
        chk("post_reset_resp", 64'(resp_seen), 64'(cnt + 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
